// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and reset-cause codes.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    GAP     = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Cause recorded for a re-run; watchdog wins over software when both fire together.
  function automatic logic [1:0] trig_cause(input logic wdt);
    return wdt ? CAUSE_WDT : CAUSE_SW;
  endfunction

endpackage

// File: rtl/rst_ack_sync.sv
// Per-bit two-flop synchronizer bringing the domain ready feedback onto clk.
module rst_ack_sync #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] rdy_async,
  output logic [WIDTH-1:0] rdy_sync
);

  logic [WIDTH-1:0] rdy_meta;

  // Two register stages; both clear to "not ready" on master reset.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rdy_meta <= '0;
      rdy_sync <= '0;
    end else begin
      rdy_meta <= rdy_async;
      rdy_sync <= rdy_meta;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds all domain resets for a stretch, then releases domains
// in index order, each gated by its synchronized acknowledge. Re-runs on a
// software request or watchdog expiry.
// Optional ack-wait timeout enabled by defining RST_SEQ_TIMEOUT_EN.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS    = 2,
  parameter int unsigned STRETCH_CYCLES = 16,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic                   WDT_EXPIRE,
  input  logic [NUM_DOMAINS-1:0] DOM_RDY,
  output logic [NUM_DOMAINS-1:0] DOM_RST_N,
  output logic                   RST_BUSY,
  output logic [1:0]             RST_CAUSE,
  output logic                   SEQ_TIMEOUT
);

  localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST      = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

`ifdef RST_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  seq_state_e             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [NUM_DOMAINS-1:0] ack_sync;
  logic                   trig;
  logic                   ack_now;
  logic                   to_hit;

  rst_ack_sync #(
    .WIDTH(NUM_DOMAINS)
  ) u_ack_sync (
    .clk      (clk),
    .RST      (RST),
    .rdy_async(DOM_RDY),
    .rdy_sync (ack_sync)
  );

  // Re-run request and ack qualification for the domain currently being released.
  assign trig    = SW_RST_REQ | WDT_EXPIRE;
  assign ack_now = ack_sync[idx];
  assign to_hit  = TO_EN && (cnt == TO_LAST);

  // Sequencer FSM with registered reset requests, busy, cause and timeout flag.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state       <= ASSERT;
      cnt         <= '0;
      idx         <= '0;
      DOM_RST_N   <= '0;
      RST_BUSY    <= 1'b1;
      RST_CAUSE   <= CAUSE_POR;
      SEQ_TIMEOUT <= 1'b0;
    end else if (state != ASSERT && trig) begin
      state     <= ASSERT;
      cnt       <= '0;
      idx       <= '0;
      DOM_RST_N <= '0;
      RST_BUSY  <= 1'b1;
      RST_CAUSE <= trig_cause(WDT_EXPIRE);
    end else begin
      case (state)
        ASSERT: begin
          // A held request pins the stretch counter; a watchdog pulse restarts it.
          if (trig) begin
            cnt <= '0;
            if (WDT_EXPIRE) RST_CAUSE <= CAUSE_WDT;
          end else if (cnt == STRETCH_LAST) begin
            state     <= RELEASE;
            idx       <= '0;
            cnt       <= '0;
            DOM_RST_N <= NUM_DOMAINS'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          // A timeout is treated exactly like an arriving ack, but leaves a flag.
          if (ack_now || to_hit) begin
            if (!ack_now) SEQ_TIMEOUT <= 1'b1;
            cnt <= '0;
            if (idx == IDX_LAST) begin
              state    <= RUN;
              RST_BUSY <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else if (TO_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= RELEASE;
            cnt       <= '0;
            idx       <= idx + IDX_W'(1);
            DOM_RST_N <= DOM_RST_N | (NUM_DOMAINS'(1) << (idx + IDX_W'(1)));
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: directed stimulus with a reset-synchronizer loopback,
// a release-count model checked every cycle, and literal edge-count checks.
module tb_rst_seq_gen;

  localparam int N       = 2;
  localparam int STRETCH = 16;
  localparam int GAPC    = 4;
  localparam int TIMEOUT = 255;

  logic         clk        = 1'b0;
  logic         RST        = 1'b0;
  logic         SW_RST_REQ = 1'b0;
  logic         WDT_EXPIRE = 1'b0;
  logic [N-1:0] DOM_RDY    = '0;
  logic [N-1:0] DOM_RST_N;
  logic         RST_BUSY;
  logic [1:0]   RST_CAUSE;
  logic         SEQ_TIMEOUT;

  int n_cmp = 0;
  int n_err = 0;

  // Environment: each domain's reset synchronizer, plus a mask to hold ready low.
  logic [N-1:0] env_s1 = '0;
  logic [N-1:0] env_s2 = '0;
  logic [N-1:0] stuck  = '0;

  always #5 clk = ~clk;

  rst_seq_gen #(
    .NUM_DOMAINS   (N),
    .STRETCH_CYCLES(STRETCH),
    .GAP_CYCLES    (GAPC),
    .CNT_W         (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .WDT_EXPIRE (WDT_EXPIRE),
    .DOM_RDY    (DOM_RDY),
    .DOM_RST_N  (DOM_RST_N),
    .RST_BUSY   (RST_BUSY),
    .RST_CAUSE  (RST_CAUSE),
    .SEQ_TIMEOUT(SEQ_TIMEOUT)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: counts released domains and remaining wait cycles in each phase.
  localparam int P_HOLD = 0, P_WAIT = 1, P_SPACE = 2, P_RUN = 3;
  int           m_phase = P_HOLD;
  int           m_rel   = 0;
  int           m_left  = STRETCH;
  int           m_wait  = 0;
  logic [1:0]   m_cause = 2'b00;
  logic         m_to    = 1'b0;
  logic [N-1:0] m_s1    = '0;
  logic [N-1:0] m_s2    = '0;

  always @(posedge clk or negedge RST) begin : model
    bit ack, go;
    if (!RST) begin
      m_phase = P_HOLD; m_rel = 0; m_left = STRETCH; m_wait = 0;
      m_cause = 2'b00;  m_to = 1'b0; m_s1 = '0; m_s2 = '0;
    end else begin
      ack = (m_rel > 0) && m_s2[m_rel-1];
      go  = 1'b0;
      if (m_phase == P_HOLD) begin
        if (WDT_EXPIRE) begin
          m_left = STRETCH; m_cause = 2'b10;
        end else if (SW_RST_REQ) begin
          m_left = STRETCH;
        end else begin
          m_left--;
          if (m_left == 0) begin m_rel = 1; m_phase = P_WAIT; m_wait = 0; end
        end
      end else if (SW_RST_REQ || WDT_EXPIRE) begin
        m_phase = P_HOLD; m_left = STRETCH; m_rel = 0;
        m_cause = WDT_EXPIRE ? 2'b10 : 2'b01;
      end else if (m_phase == P_WAIT) begin
        if (ack) go = 1'b1;
        else begin
          m_wait++;
`ifdef RST_SEQ_TIMEOUT_EN
          if (m_wait == TIMEOUT) begin m_to = 1'b1; go = 1'b1; end
`endif
        end
        if (go) begin
          if (m_rel == N) m_phase = P_RUN;
          else begin m_phase = P_SPACE; m_left = GAPC; end
        end
      end else if (m_phase == P_SPACE) begin
        m_left--;
        if (m_left == 0) begin m_rel++; m_phase = P_WAIT; m_wait = 0; end
      end
      m_s2 = m_s1;
      m_s1 = DOM_RDY;
    end
  end

  function automatic logic [N-1:0] exp_dom();
    logic [N-1:0] e = '0;
    for (int i = 0; i < N; i++) if (i < m_rel) e[i] = 1'b1;
    return e;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("dom_rst_n", 32'(DOM_RST_N), 32'(exp_dom()));
    chk("rst_busy", 32'(RST_BUSY), 32'(m_phase != P_RUN));
    chk("rst_cause", 32'(RST_CAUSE), 32'(m_cause));
    chk("seq_timeout", 32'(SEQ_TIMEOUT), 32'(m_to));
  end

  task automatic step();
    @(posedge clk); #1;
    env_s2  = env_s1 & DOM_RST_N;
    env_s1  = DOM_RST_N;
    DOM_RDY = env_s2 & DOM_RST_N & ~stuck;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0:       return DOM_RST_N[0] === 1'b1;
      1:       return DOM_RST_N[1] === 1'b1;
      2:       return RST_BUSY === 1'b0;
      default: return SEQ_TIMEOUT === 1'b1;
    endcase
  endfunction

  task automatic wait_edges(input int sel, input int max, input string name, output int n);
    n = 0;
    while (!cond(sel) && n < max) begin step(); n++; end
    if (!cond(sel)) begin
      n_cmp++; n_err++;
      $display("FAIL %s: event not seen after %0d edges, expected within %0d", name, n, max);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dom"}, 32'(DOM_RST_N), 32'h0);
    chk({tag, "_busy"}, 32'(RST_BUSY), 32'h1);
    chk({tag, "_cause"}, 32'(RST_CAUSE), 32'h0);
    chk({tag, "_to"}, 32'(SEQ_TIMEOUT), 32'h0);
  endtask

  initial begin
    int n;
    repeat (3) step();
    chk_reset_vals("reset");

    // Power-on sequence.
    RST = 1'b1;
    wait_edges(0, 100, "por_dom0", n);  chk("por_dom0_edges", n, 16);
    wait_edges(1, 100, "por_dom1", n);  chk("por_dom1_edges", n, 8);
    wait_edges(2, 100, "por_busy", n);  chk("por_busy_edges", n, 4);
    chk("por_cause", 32'(RST_CAUSE), 32'h0);

    // Ready dropping while running is ignored.
    stuck = 2'b11;
    repeat (6) step();
    chk("drop_busy", 32'(RST_BUSY), 32'h0);
    chk("drop_dom", 32'(DOM_RST_N), 32'h3);
    stuck = 2'b00;
    repeat (4) step();

    // Software request held for 10 cycles.
    SW_RST_REQ = 1'b1;
    step();
    chk("sw_dom", 32'(DOM_RST_N), 32'h0);
    chk("sw_cause", 32'(RST_CAUSE), 32'h1);
    chk("sw_busy", 32'(RST_BUSY), 32'h1);
    repeat (9) step();
    SW_RST_REQ = 1'b0;
    wait_edges(0, 100, "sw_dom0", n);   chk("sw_dom0_edges", n, 16);
    wait_edges(2, 100, "sw_busy", n);   chk("sw_busy_edges", n, 12);

    // Software and watchdog in the same cycle: watchdog wins.
    SW_RST_REQ = 1'b1; WDT_EXPIRE = 1'b1;
    step();
    SW_RST_REQ = 1'b0; WDT_EXPIRE = 1'b0;
    chk("both_cause", 32'(RST_CAUSE), 32'h2);
    chk("both_dom", 32'(DOM_RST_N), 32'h0);
    wait_edges(2, 100, "both_busy", n); chk("both_busy_edges", n, 28);

    // Watchdog pulse while spacing after domain 0.
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    wait_edges(0, 100, "gap_dom0", n);  chk("gap_dom0_edges", n, 16);
    repeat (4) step();
    chk("gap_dom_before", 32'(DOM_RST_N), 32'h1);
    WDT_EXPIRE = 1'b1;
    step();
    WDT_EXPIRE = 1'b0;
    chk("gap_dom_after", 32'(DOM_RST_N), 32'h0);
    chk("gap_cause", 32'(RST_CAUSE), 32'h2);
    chk("gap_busy", 32'(RST_BUSY), 32'h1);
    wait_edges(0, 100, "gap_restart", n); chk("gap_restart_edges", n, 16);

    // Master reset pulse while waiting for domain 0's ack.
    step();
    RST = 1'b0;
    #1;
    chk_reset_vals("midrst");
    step();
    RST = 1'b1;
    wait_edges(0, 100, "rst_dom0", n);  chk("rst_dom0_edges", n, 16);
    wait_edges(1, 100, "rst_dom1", n);  chk("rst_dom1_edges", n, 8);
    wait_edges(2, 100, "rst_busy", n);  chk("rst_busy_edges", n, 4);
    chk("rst_cause", 32'(RST_CAUSE), 32'h0);

`ifdef RST_SEQ_TIMEOUT_EN
    // Domain 0 never acknowledges: timeout, then the sequence carries on.
    stuck = 2'b01;
    SW_RST_REQ = 1'b1;
    step();
    SW_RST_REQ = 1'b0;
    wait_edges(0, 100, "to_dom0", n);   chk("to_dom0_edges", n, 16);
    wait_edges(3, 400, "to_flag", n);   chk("to_flag_edges", n, 255);
    wait_edges(1, 100, "to_dom1", n);   chk("to_dom1_edges", n, 4);
    stuck = 2'b00;
    wait_edges(2, 100, "to_busy", n);   chk("to_busy_edges", n, 4);
    chk("to_sticky", 32'(SEQ_TIMEOUT), 32'h1);
`endif

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "bench watchdog expired");
  end

endmodule
